// File: rtl/riscv_insn_encoder.sv
// riscv_insn_encoder
// Packs RV32I instruction fields plus a sign-extended immediate into a 32-bit
// instruction word. The work is split over two pipeline stages:
//   - Stage 1 checks the fields for the chosen format.
//   - Stage 2 packs the word.
// Both stages use a valid/ready handshake that does not insert bubbles.
// Saturating counters track delivered good words and delivered rejected words.
module riscv_insn_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_insn,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] insn_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Flags opcode, format or immediate values that cannot be encoded.
    // Fields that the format does not use are not checked.
    function automatic logic field_err(input logic [2:0]  fmt,
                                       input logic [6:0]  op,
                                       input logic [31:0] imm);
        logic signed [31:0] simm;
        logic               e;
        simm = $signed(imm);
        e    = (op[1:0] != 2'b11);
        case (fmt)
            FMT_R:        e = e;
            FMT_I, FMT_S: e = e | (simm < -32'sd2048) | (simm > 32'sd2047);
            FMT_B:        e = e | (simm < -32'sd4096) | (simm > 32'sd4094) | imm[0];
            FMT_U:        e = e | (imm[11:0] != 12'h000);
            FMT_J:        e = e | (simm < -32'sd1048576) | (simm > 32'sd1048574) | imm[0];
            default:      e = 1'b1;
        endcase
        return e;
    endfunction

    // Standard RV32 bit layouts for the six base formats.
    function automatic logic [31:0] pack(input logic [2:0]  fmt,
                                         input logic [6:0]  op,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [2:0]  f3,
                                         input logic [6:0]  f7,
                                         input logic [31:0] imm);
        logic [31:0] w;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic        s1_v_r;
    logic        s1_err_r;
    logic [2:0]  s1_fmt_r;
    logic [6:0]  s1_op_r;
    logic [4:0]  s1_rd_r;
    logic [4:0]  s1_rs1_r;
    logic [4:0]  s1_rs2_r;
    logic [2:0]  s1_f3_r;
    logic [6:0]  s1_f7_r;
    logic [31:0] s1_imm_r;

    logic        s2_v_r;
    logic        out_err_r;
    logic [31:0] out_insn_r;

    logic [CNT_W-1:0] insn_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;

    logic s1_adv_s;
    logic in_ready_s;

    // Stage 1 may move forward when stage 2 is empty or is draining this cycle.
    always_comb begin
        s1_adv_s   = !s2_v_r || out_ready;
        in_ready_s = !s1_v_r || s1_adv_s;
    end

    // Stage 1: capture the input fields and their validity check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_err_r <= 1'b0;
            s1_fmt_r <= 3'd0;
            s1_op_r  <= 7'd0;
            s1_rd_r  <= 5'd0;
            s1_rs1_r <= 5'd0;
            s1_rs2_r <= 5'd0;
            s1_f3_r  <= 3'd0;
            s1_f7_r  <= 7'd0;
            s1_imm_r <= 32'd0;
        end else if (in_ready_s) begin
            s1_v_r <= in_valid;
            if (in_valid) begin
                s1_err_r <= field_err(in_fmt, in_opcode, in_imm);
                s1_fmt_r <= in_fmt;
                s1_op_r  <= in_opcode;
                s1_rd_r  <= in_rd;
                s1_rs1_r <= in_rs1;
                s1_rs2_r <= in_rs2;
                s1_f3_r  <= in_funct3;
                s1_f7_r  <= in_funct7;
                s1_imm_r <= in_imm;
            end
        end
    end

    // Stage 2: pack the word. The word is held while the output is stalled,
    // and a rejected word is forced to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r     <= 1'b0;
            out_err_r  <= 1'b0;
            out_insn_r <= 32'h0000_0000;
        end else if (s1_adv_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                out_err_r  <= s1_err_r;
                out_insn_r <= s1_err_r ? 32'h0000_0000 :
                              pack(s1_fmt_r, s1_op_r, s1_rd_r, s1_rs1_r, s1_rs2_r,
                                   s1_f3_r, s1_f7_r, s1_imm_r);
            end
        end
    end

    // Saturating delivery counters. A same-cycle clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r  <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            insn_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r  <= {CNT_W{1'b0}};
        end else if (s2_v_r && out_ready) begin
            if (out_err_r) begin
                if (err_cnt_r != {CNT_W{1'b1}}) begin
                    err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                if (insn_cnt_r != {CNT_W{1'b1}}) begin
                    insn_cnt_r <= insn_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_v_r;
    assign out_err   = out_err_r;
    assign out_insn  = out_insn_r;
    assign insn_cnt  = insn_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_riscv_insn_encoder.sv
// Bench for riscv_insn_encoder.
// - Two instances share one input stream: a 16-bit counter build and a 2-bit
//   counter build, so that counter saturation can be checked.
// - A field-level encoding model feeds a queue of expected words. A
//   negedge monitor checks every delivered word, the counters and in_ready.
// - Directed vectors pin the model and the latency with literal values.
module tb_riscv_insn_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_insn;
    logic [15:0] insn_cnt, err_cnt;
    logic        in_ready2, out_valid2, out_err2;
    logic [31:0] out_insn2;
    logic [1:0]  insn_cnt2, err_cnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] fmt, op, rd, rs1, rs2, f3, f7, imm;
    } stim_t;

    logic [32:0] expq[$];
    logic [15:0] m_icnt, m_ecnt;
    logic [1:0]  m2_icnt, m2_ecnt;

    always #5 clk = ~clk;

    riscv_insn_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
        .out_err(out_err), .cnt_clr(cnt_clr), .insn_cnt(insn_cnt), .err_cnt(err_cnt)
    );

    riscv_insn_encoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready), .out_insn(out_insn2),
        .out_err(out_err2), .cnt_clr(cnt_clr), .insn_cnt(insn_cnt2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected {err, word}: range rules on the signed immediate, then each field
    // is placed at its bit position by arithmetic shifts.
    function automatic logic [32:0] model(input stim_t s);
        longint      simm;
        logic        e;
        logic [31:0] w;
        simm = longint'($signed(s.imm));
        e    = (s.op % 4) != 3;
        w    = 32'd0;
        case (s.fmt)
            32'd0: w = (s.f7 << 25) | (s.rs2 << 20) | (s.rs1 << 15) | (s.f3 << 12) | (s.rd << 7) | s.op;
            32'd1: begin
                e = e | (simm < -2048) | (simm > 2047);
                w = ((s.imm & 32'hFFF) << 20) | (s.rs1 << 15) | (s.f3 << 12) | (s.rd << 7) | s.op;
            end
            32'd2: begin
                e = e | (simm < -2048) | (simm > 2047);
                w = (((s.imm >> 5) & 32'h7F) << 25) | (s.rs2 << 20) | (s.rs1 << 15) | (s.f3 << 12)
                    | ((s.imm & 32'h1F) << 7) | s.op;
            end
            32'd3: begin
                e = e | (simm < -4096) | (simm > 4094) | ((s.imm % 2) != 0);
                w = (((s.imm >> 12) & 32'h1) << 31) | (((s.imm >> 5) & 32'h3F) << 25) | (s.rs2 << 20)
                    | (s.rs1 << 15) | (s.f3 << 12) | (((s.imm >> 1) & 32'hF) << 8)
                    | (((s.imm >> 11) & 32'h1) << 7) | s.op;
            end
            32'd4: begin
                e = e | ((s.imm % 4096) != 0);
                w = (s.imm & 32'hFFFF_F000) | (s.rd << 7) | s.op;
            end
            32'd5: begin
                e = e | (simm < -1048576) | (simm > 1048574) | ((s.imm % 2) != 0);
                w = (((s.imm >> 20) & 32'h1) << 31) | (((s.imm >> 1) & 32'h3FF) << 21)
                    | (((s.imm >> 11) & 32'h1) << 20) | (((s.imm >> 12) & 32'hFF) << 12)
                    | (s.rd << 7) | s.op;
            end
            default: e = 1'b1;
        endcase
        return {e, e ? 32'd0 : w};
    endfunction

    function automatic stim_t mk(input int fmt, input int op, input int rd, input int rs1,
                                 input int rs2, input int f3, input int f7, input logic [31:0] imm);
        stim_t s;
        s.fmt = fmt; s.op = op; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.f3 = f3; s.f7 = f7; s.imm = imm;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        in_fmt    = s.fmt[2:0];
        in_opcode = s.op[6:0];
        in_rd     = s.rd[4:0];
        in_rs1    = s.rs1[4:0];
        in_rs2    = s.rs2[4:0];
        in_funct3 = s.f3[2:0];
        in_funct7 = s.f7[6:0];
        in_imm    = s.imm;
    endtask

    // Monitor: runs on the negedge while the inputs are stable.
    always @(negedge clk) begin
        stim_t       cs;
        logic [32:0] e;
        if (!rst_n) begin
            expq.delete();
            m_icnt = 16'd0; m_ecnt = 16'd0; m2_icnt = 2'd0; m2_ecnt = 2'd0;
        end else begin
            chk("insn_cnt", {16'd0, insn_cnt}, {16'd0, m_icnt});
            chk("err_cnt", {16'd0, err_cnt}, {16'd0, m_ecnt});
            chk("insn_cnt2", {30'd0, insn_cnt2}, {30'd0, m2_icnt});
            chk("err_cnt2", {30'd0, err_cnt2}, {30'd0, m2_ecnt});
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(expq.size() == 2 && !out_ready)});
            chk("in_ready2", {31'd0, in_ready2}, {31'd0, !(expq.size() == 2 && !out_ready)});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("out_insn", out_insn, e[31:0]);
                    chk("out_err", {31'd0, out_err}, {31'd0, e[32]});
                    chk("out_insn2", out_insn2, e[31:0]);
                    chk("out_valid2", {31'd0, out_valid2}, 32'd1);
                    if (e[32]) begin
                        if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
                        if (m2_ecnt != 2'd3) m2_ecnt = m2_ecnt + 2'd1;
                    end else begin
                        if (m_icnt != 16'hFFFF) m_icnt = m_icnt + 16'd1;
                        if (m2_icnt != 2'd3) m2_icnt = m2_icnt + 2'd1;
                    end
                end
            end
            if (cnt_clr) begin
                m_icnt = 16'd0; m_ecnt = 16'd0; m2_icnt = 2'd0; m2_ecnt = 2'd0;
            end
            if (in_valid && in_ready) begin
                cs = mk(int'(in_fmt), int'(in_opcode), int'(in_rd), int'(in_rs1), int'(in_rs2),
                        int'(in_funct3), int'(in_funct7), in_imm);
                expq.push_back(model(cs));
            end
        end
    end

    // Send one word into an empty pipeline with out_ready=1 and check the
    // two-cycle latency against the given expectation.
    task automatic send_one(input string nm, input stim_t s, input logic [32:0] exp);
        drive(s);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_insn"}, out_insn, exp[31:0]);
        chk({nm, "_err"}, {31'd0, out_err}, {31'd0, exp[32]});
        @(posedge clk); #1;
    endtask

    initial begin
        stim_t st;
        stim_t sv[8];
        int    sent;
        int    cyc;
        logic  acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 32'd0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_insn", out_insn, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_insn_cnt", {16'd0, insn_cnt}, 32'd0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);

        // Literal pins on the model itself.
        chk("m_add", model(mk(0, 'h33, 3, 1, 2, 0, 0, 32'd0)), {1'b0, 32'h002081B3});
        chk("m_addi", model(mk(1, 'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF)), {1'b0, 32'hFFF00093});
        chk("m_sw", model(mk(2, 'h23, 0, 1, 2, 2, 0, 32'd8)), {1'b0, 32'h0020A423});
        chk("m_jal", model(mk(5, 'h6F, 1, 0, 0, 0, 0, 32'd2048)), {1'b0, 32'h001000EF});
        chk("m_lui", model(mk(4, 'h37, 5, 0, 0, 0, 0, 32'h12345000)), {1'b0, 32'h123452B7});

        // Directed words: 7 good and 6 rejected.
        send_one("add", mk(0, 'h33, 3, 1, 2, 0, 0, 32'd0), {1'b0, 32'h002081B3});
        send_one("addi", mk(1, 'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF), {1'b0, 32'hFFF00093});
        send_one("i2048", mk(1, 'h13, 1, 0, 0, 0, 0, 32'd2048), {1'b1, 32'h0});
        send_one("sw", mk(2, 'h23, 0, 1, 2, 2, 0, 32'd8), {1'b0, 32'h0020A423});
        send_one("jal", mk(5, 'h6F, 1, 0, 0, 0, 0, 32'd2048), {1'b0, 32'h001000EF});
        send_one("b3", mk(3, 'h63, 0, 1, 2, 0, 0, 32'd3), {1'b1, 32'h0});
        send_one("lui", mk(4, 'h37, 5, 0, 0, 0, 0, 32'h12345000), {1'b0, 32'h123452B7});
        st = mk(3, 'h63, 0, 4, 5, 1, 0, -32'sd4096);
        send_one("b_min", st, model(st));
        send_one("b4096", mk(3, 'h63, 0, 4, 5, 1, 0, 32'd4096), {1'b1, 32'h0});
        st = mk(5, 'h6F, 7, 0, 0, 0, 0, 32'd1048574);
        send_one("j_max", st, model(st));
        send_one("fmt6", mk(6, 'h33, 1, 1, 1, 0, 0, 32'd0), {1'b1, 32'h0});
        send_one("op_lo", mk(0, 'h32, 1, 1, 1, 0, 0, 32'd0), {1'b1, 32'h0});
        send_one("u_low", mk(4, 'h37, 5, 0, 0, 0, 0, 32'h12345001), {1'b1, 32'h0});
        chk("dir_insn_cnt", {16'd0, insn_cnt}, 32'd7);
        chk("dir_err_cnt", {16'd0, err_cnt}, 32'd6);
        chk("sat_insn_cnt2", {30'd0, insn_cnt2}, 32'd3);
        chk("sat_err_cnt2", {30'd0, err_cnt2}, 32'd3);

        // Clear in the same cycle as a delivery: the clear wins.
        drive(mk(0, 'h33, 3, 1, 2, 0, 0, 32'd0));
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 cnt_clr = 1'b1;
        chk("clr_deliv_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1 cnt_clr = 1'b0;
        chk("clr_insn_cnt", {16'd0, insn_cnt}, 32'd0);
        chk("clr_insn_cnt2", {30'd0, insn_cnt2}, 32'd0);
        chk("clr_err_cnt", {16'd0, err_cnt}, 32'd0);

        // Stream of 8 distinct words with out_ready toggling every cycle.
        for (int i = 0; i < 8; i++) sv[i] = mk(0, 'h33, i + 1, i, 31 - i, i % 8, i * 3, 32'd0);
        sent = 0; cyc = 0;
        while (sent < 8 && cyc < 100) begin
            out_ready = cyc[0];
            drive(sv[sent]);
            in_valid = 1'b1;
            @(negedge clk) acc = in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        if (cyc >= 100) chk("stream_timeout", 32'd1, 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_drained", expq.size(), 32'd0);
        chk("stream_insn_cnt", {16'd0, insn_cnt}, 32'd8);
        chk("stream_insn_cnt2", {30'd0, insn_cnt2}, 32'd3);

        // Fill the pipeline, then reset asynchronously while words are in flight.
        drive(mk(1, 'h13, 2, 3, 0, 0, 0, 32'd5));
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("full_valid", {31'd0, out_valid}, 32'd1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_insn_cnt", {16'd0, insn_cnt}, 32'd0);
        chk("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        send_one("post_rst", mk(0, 'h33, 3, 1, 2, 0, 0, 32'd0), {1'b0, 32'h002081B3});
        chk("post_rst_cnt", {16'd0, insn_cnt}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
